// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the audio PLL lock sequencer.
package pll_seq_pkg;

  localparam int STATE_W    = 3;
  localparam int LOSS_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared to 0 by rst_n.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Metastability filter: d is sampled twice before anyone sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Audio PLL reset/lock sequencer on the 50 MHz reference clock.
// Optional lock-loss counter enabled by defining PLL_LOCK_LOSS_CNT_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 50,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int SETTLE_CYCLES = 5000,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_W         = 16
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               restart,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               audio_rst_n,
  output logic               ready,
  output logic               fault,
  output logic [STATE_W-1:0] state,
  output logic [2:0]         retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

  logic             locked_s;
  pll_state_e       state_r;
  pll_state_e       nxt_state_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] nxt_timer_s;
  logic [2:0]       nxt_retry_s;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Next-state, retry and timer decision; restart overrides everything.
  always_comb begin
    nxt_state_s = state_r;
    nxt_retry_s = retry_cnt;
    if (restart) begin
      nxt_state_s = ST_RESET_PLL;
      nxt_retry_s = 3'd0;
    end else begin
      case (state_r)
        ST_RESET_PLL: begin
          if (timer_r == RST_LAST) nxt_state_s = ST_WAIT_LOCK;
          else                     nxt_state_s = ST_RESET_PLL;
        end
        ST_WAIT_LOCK: begin
          // A lock seen on the timeout cycle still counts as a lock.
          if (locked_s) begin
            nxt_state_s = ST_SETTLE;
          end else if (timer_r == TIMEOUT_LAST) begin
            nxt_retry_s = retry_cnt + 3'd1;
            if (nxt_retry_s == RETRY_LIMIT) nxt_state_s = ST_FAULT;
            else                            nxt_state_s = ST_RESET_PLL;
          end else begin
            nxt_state_s = ST_WAIT_LOCK;
          end
        end
        ST_SETTLE: begin
          if (!locked_s)                   nxt_state_s = ST_WAIT_LOCK;
          else if (timer_r == SETTLE_LAST) nxt_state_s = ST_RUN;
          else                             nxt_state_s = ST_SETTLE;
        end
        ST_RUN: begin
          if (!locked_s) nxt_state_s = ST_RESET_PLL;
          else           nxt_state_s = ST_RUN;
        end
        ST_FAULT: nxt_state_s = ST_FAULT;
        default:  nxt_state_s = ST_RESET_PLL;
      endcase
    end
    if (nxt_state_s == ST_RUN) nxt_retry_s = 3'd0;
    else                       nxt_retry_s = nxt_retry_s;
    if (restart || (nxt_state_s != state_r)) nxt_timer_s = '0;
    else                                     nxt_timer_s = timer_r + CNT_W'(1);
  end

  // State, timer and Moore outputs decoded from the next state so they move together.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RESET_PLL;
      timer_r     <= '0;
      retry_cnt   <= 3'd0;
      pll_rst     <= 1'b1;
      audio_rst_n <= 1'b0;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_r     <= nxt_state_s;
      timer_r     <= nxt_timer_s;
      retry_cnt   <= nxt_retry_s;
      pll_rst     <= (nxt_state_s == ST_RESET_PLL) || (nxt_state_s == ST_FAULT);
      audio_rst_n <= (nxt_state_s == ST_RUN);
      ready       <= (nxt_state_s == ST_RUN);
      fault       <= (nxt_state_s == ST_FAULT);
    end
  end

  assign state = state_r;

`ifdef PLL_LOCK_LOSS_CNT_EN
  // Saturating count of lock drops seen while running; restart does not count.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt <= '0;
    end else if ((state_r == ST_RUN) && !locked_s && !restart &&
                 (lock_loss_cnt != {LOSS_CNT_W{1'b1}})) begin
      lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
    end else begin
      lock_loss_cnt <= lock_loss_cnt;
    end
  end
`endif

endmodule
